// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: counter encodings,
// prediction record and PC field extraction helpers.
package bp_pkg;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   // New entries start weakly taken so one not-taken outcome flips them.
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   typedef struct packed {
      logic        valid;
      logic        taken;
      logic [31:0] target;
   } pred_t;

   // Word index of a PC; byte offset bits [1:0] never participate.
   function automatic logic [31:0] pc_index(input logic [31:0] pc, input int index_bits);
      return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
   endfunction

   // Tag field sitting directly above the index field.
   function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int index_bits,
                                          input int tag_bits);
      return (pc >> (index_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch/resolve/statistics bundle between the pipeline and the BTB.
interface branch_target_buffer_if;
   logic [31:0] Fetch_PC;
   logic        STALL;
   logic        FLUSH;
   logic        Predict_Valid;
   logic        Predict_Taken;
   logic [31:0] Predict_Target;
   logic        Update_Valid;
   logic [31:0] Update_PC;
   logic        Update_Taken;
   logic [31:0] Update_Target;
   logic [31:0] Lookup_Count;
   logic [31:0] Hit_Count;

   // Pipeline side: drives fetch/resolve, consumes predictions.
   modport master (
      output Fetch_PC, STALL, FLUSH, Update_Valid, Update_PC, Update_Taken, Update_Target,
      input  Predict_Valid, Predict_Taken, Predict_Target, Lookup_Count, Hit_Count
   );

   // BTB side.
   modport slave (
      input  Fetch_PC, STALL, FLUSH, Update_Valid, Update_PC, Update_Taken, Update_Target,
      output Predict_Valid, Predict_Taken, Predict_Target, Lookup_Count, Hit_Count
   );
endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next state of a 2-bit saturating direction counter.
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] nxt
);

   // Step toward the resolved direction, pinning at either end.
   always_comb begin
      nxt = cur;
      if (taken) begin
         if (cur != CTR_ST) nxt = cur + 2'd1;
      end else begin
         if (cur != CTR_SNT) nxt = cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry 2-bit direction counters. Registered
// next-PC prediction one cycle after Fetch_PC; ID writes outcomes back.
module branch_target_buffer
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 24
) (
   input logic                   CLK,
   input logic                   RESET,
   branch_target_buffer_if.slave bus
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   pred_t       pred_q;
   logic [31:0] lookup_q;
   logic [31:0] hit_q;

   logic [31:0] f_idx32, f_tag32, u_idx32, u_tag32;
   logic [INDEX_BITS-1:0] f_idx, u_idx;
   logic [TAG_BITS-1:0]   f_tag, u_tag;
   logic                  f_hit, u_hit;
   logic [1:0]            u_ctr_nxt;
   logic                  unused_bits;

   assign f_idx32 = pc_index(bus.Fetch_PC, INDEX_BITS);
   assign f_tag32 = pc_tag(bus.Fetch_PC, INDEX_BITS, TAG_BITS);
   assign u_idx32 = pc_index(bus.Update_PC, INDEX_BITS);
   assign u_tag32 = pc_tag(bus.Update_PC, INDEX_BITS, TAG_BITS);
   assign f_idx   = f_idx32[INDEX_BITS-1:0];
   assign f_tag   = f_tag32[TAG_BITS-1:0];
   assign u_idx   = u_idx32[INDEX_BITS-1:0];
   assign u_tag   = u_tag32[TAG_BITS-1:0];
   assign unused_bits = ^{f_idx32[31:INDEX_BITS], f_tag32[31:TAG_BITS],
                          u_idx32[31:INDEX_BITS], u_tag32[31:TAG_BITS]};

   // Both ports read the arrays before this edge's write: read-before-write.
   assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   sat_counter2 u_ctr (
      .cur   (ctr_q[u_idx]),
      .taken (bus.Update_Taken),
      .nxt   (u_ctr_nxt)
   );

   // Prediction register and statistics: reset > flush > stall > lookup.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pred_q   <= '0;
         lookup_q <= '0;
         hit_q    <= '0;
      end else if (bus.FLUSH) begin
         pred_q   <= '0;
      end else if (!bus.STALL) begin
         pred_q.valid  <= f_hit;
         pred_q.taken  <= f_hit && ctr_q[f_idx][1];
         pred_q.target <= f_hit ? target_q[f_idx] : bus.Fetch_PC + 32'd4;
         lookup_q      <= lookup_q + 32'd1;
         if (f_hit) hit_q <= hit_q + 32'd1;
      end
   end

   // Valid bits: cleared together on reset, set when a taken miss allocates.
   always_ff @(posedge CLK) begin
      if (RESET) valid_q <= '0;
      else if (bus.Update_Valid && !u_hit && bus.Update_Taken) valid_q[u_idx] <= 1'b1;
   end

   // Entry payload: never reset, and an update coinciding with reset is dropped.
   always_ff @(posedge CLK) begin
      if (!RESET && bus.Update_Valid) begin
         if (u_hit) begin
            ctr_q[u_idx] <= u_ctr_nxt;
            if (bus.Update_Taken) target_q[u_idx] <= bus.Update_Target;
         end else if (bus.Update_Taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.Update_Target;
            ctr_q[u_idx]    <= CTR_ALLOC;
         end
      end
   end

   assign bus.Predict_Valid  = pred_q.valid;
   assign bus.Predict_Taken  = pred_q.taken;
   assign bus.Predict_Target = pred_q.target;
   assign bus.Lookup_Count   = lookup_q;
   assign bus.Hit_Count      = hit_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios followed
// by random traffic, all compared against a table-based reference model.
module tb_branch_target_buffer;

   logic CLK;
   logic RESET;
   branch_target_buffer_if bus();

   branch_target_buffer #(.INDEX_BITS(6), .TAG_BITS(24)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: 64 entries, counters held as plain integers 0..3.
   bit          m_valid [64];
   int unsigned m_tag   [64];
   int unsigned m_tgt   [64];
   int          m_ctr   [64];
   bit          e_valid, e_taken;
   int unsigned e_target, e_lookups, e_hits;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned idx_of(input int unsigned pc);
      return (pc / 4) % 64;
   endfunction

   function automatic int unsigned tag_of(input int unsigned pc);
      return (pc / 256) % (1 << 24);
   endfunction

   // Advance the reference model across one clock edge.
   task automatic model_edge(input bit rst, input int unsigned fpc, input bit stl, input bit fl,
                             input bit uv, input int unsigned upc, input bit ut,
                             input int unsigned utg);
      int unsigned fi, ui;
      bit fh, uh;
      if (rst) begin
         for (int i = 0; i < 64; i++) m_valid[i] = 0;
         e_valid = 0; e_taken = 0; e_target = 0; e_lookups = 0; e_hits = 0;
         return;
      end
      if (fl) begin
         e_valid = 0; e_taken = 0; e_target = 0;
      end else if (!stl) begin
         fi = idx_of(fpc);
         fh = m_valid[fi] && (m_tag[fi] == tag_of(fpc));
         e_valid  = fh;
         e_taken  = fh && (m_ctr[fi] >= 2);
         e_target = fh ? m_tgt[fi] : fpc + 4;
         e_lookups++;
         if (fh) e_hits++;
      end
      if (uv) begin
         ui = idx_of(upc);
         uh = m_valid[ui] && (m_tag[ui] == tag_of(upc));
         if (uh) begin
            if (ut) begin
               if (m_ctr[ui] < 3) m_ctr[ui]++;
               m_tgt[ui] = utg;
            end else if (m_ctr[ui] > 0) m_ctr[ui]--;
         end else if (ut) begin
            m_valid[ui] = 1; m_tag[ui] = tag_of(upc); m_tgt[ui] = utg; m_ctr[ui] = 2;
         end
      end
   endtask

   // Drive one cycle of stimulus (called at negedge), then check after the edge.
   task automatic step(input bit rst, input logic [31:0] fpc, input bit stl, input bit fl,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg);
      RESET = rst;
      bus.Fetch_PC = fpc; bus.STALL = stl; bus.FLUSH = fl;
      bus.Update_Valid = uv; bus.Update_PC = upc; bus.Update_Taken = ut;
      bus.Update_Target = utg;
      model_edge(rst, fpc, stl, fl, uv, upc, ut, utg);
      @(posedge CLK);
      @(negedge CLK);
      chk("valid",   {31'd0, bus.Predict_Valid}, {31'd0, e_valid});
      chk("taken",   {31'd0, bus.Predict_Taken}, {31'd0, e_taken});
      chk("target",  bus.Predict_Target, e_target);
      chk("lookups", bus.Lookup_Count, e_lookups);
      chk("hits",    bus.Hit_Count, e_hits);
   endtask

   task automatic lookup(input logic [31:0] fpc);
      step(0, fpc, 0, 0, 0, 32'h0, 0, 32'h0);
   endtask

   task automatic update(input logic [31:0] fpc, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utg);
      step(0, fpc, 0, 0, 1, upc, ut, utg);
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] base;
      case ($urandom_range(0, 4))
         0, 1:    base = 32'h0040_0000;
         2:       base = 32'h0040_0100;
         3:       base = 32'h7FFF_FF00;
         default: base = 32'hFFFF_FFE0;
      endcase
      return base + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
   endfunction

   initial begin
      RESET = 1; bus.Fetch_PC = 0; bus.STALL = 0; bus.FLUSH = 0;
      bus.Update_Valid = 0; bus.Update_PC = 0; bus.Update_Taken = 0; bus.Update_Target = 0;
      @(negedge CLK);

      // Reset, first lookup misses with fall-through target.
      step(1, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
      step(1, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
      chk("rst_valid", {31'd0, bus.Predict_Valid}, 32'd0);
      chk("rst_target", bus.Predict_Target, 32'h0);
      lookup(32'h0040_0020);
      chk("miss_target", bus.Predict_Target, 32'h0040_0024);
      chk("miss_lookups", bus.Lookup_Count, 32'd1);
      chk("miss_hits", bus.Hit_Count, 32'd0);

      // Allocate, then hit as weakly taken.
      update(32'h0040_0020, 32'h0040_0020, 1, 32'h0040_0100);
      chk("rbw_valid", {31'd0, bus.Predict_Valid}, 32'd0);
      lookup(32'h0040_0020);
      chk("hit_valid", {31'd0, bus.Predict_Valid}, 32'd1);
      chk("hit_taken", {31'd0, bus.Predict_Taken}, 32'd1);
      chk("hit_target", bus.Predict_Target, 32'h0040_0100);
      chk("hit_count", bus.Hit_Count, 32'd1);

      // Counter walks down and saturates, then up and saturates.
      update(32'h0000_0800, 32'h0040_0020, 0, 32'h0);
      update(32'h0000_0800, 32'h0040_0020, 0, 32'h0);
      lookup(32'h0040_0020);
      chk("snt_taken", {31'd0, bus.Predict_Taken}, 32'd0);
      update(32'h0000_0800, 32'h0040_0022, 0, 32'h0);
      for (int i = 0; i < 3; i++) update(32'h0000_0800, 32'h0040_0020, 1, 32'h0040_0100);
      update(32'h0000_0800, 32'h0040_0020, 1, 32'h0040_0200);
      update(32'h0000_0800, 32'h0040_0020, 0, 32'h0);
      lookup(32'h0040_0020);
      chk("st_sat_taken", {31'd0, bus.Predict_Taken}, 32'd1);
      chk("st_target", bus.Predict_Target, 32'h0040_0200);

      // Alias at index 8 evicts the resident entry.
      lookup(32'h0040_0120);
      chk("alias_valid", {31'd0, bus.Predict_Valid}, 32'd0);
      chk("alias_target", bus.Predict_Target, 32'h0040_0124);
      update(32'h0000_0800, 32'h0040_0120, 1, 32'h0040_0500);
      lookup(32'h0040_0020);
      chk("evicted_valid", {31'd0, bus.Predict_Valid}, 32'd0);

      // Same-cycle lookup and allocation.
      update(32'h0040_0040, 32'h0040_0040, 1, 32'h0040_0800);
      chk("same_cyc_valid", {31'd0, bus.Predict_Valid}, 32'd0);
      lookup(32'h0040_0040);
      chk("next_cyc_valid", {31'd0, bus.Predict_Valid}, 32'd1);

      // Stall freezes outputs and statistics while updates still land.
      step(0, 32'h0040_0120, 1, 0, 0, 32'h0, 0, 32'h0);
      step(0, 32'h0040_0020, 1, 0, 1, 32'h0040_0060, 1, 32'h1234_5678);
      step(0, 32'h0040_0444, 1, 0, 0, 32'h0, 0, 32'h0);
      chk("stall_target", bus.Predict_Target, 32'h0040_0800);
      lookup(32'h0040_0060);
      chk("stall_upd_target", bus.Predict_Target, 32'h1234_5678);
      step(0, 32'h0040_0060, 1, 1, 0, 32'h0, 0, 32'h0);
      chk("flush_valid", {31'd0, bus.Predict_Valid}, 32'd0);

      // Reset mid-stream discards the coincident update.
      step(1, 32'h0040_0060, 0, 0, 1, 32'h0040_0080, 1, 32'h0040_0900);
      lookup(32'h0040_0060);
      lookup(32'h0040_0080);
      chk("post_rst_valid", {31'd0, bus.Predict_Valid}, 32'd0);
      lookup(32'hFFFF_FFFC);
      chk("wrap_target", bus.Predict_Target, 32'h0);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 99) == 0, rand_pc(), $urandom_range(0, 9) == 0,
              $urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1, rand_pc(),
              $urandom_range(0, 2) != 0, $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
